vx_cache_flush_ctrl: RTL
========================

VX_CACHE_FLUSH_CTRL -- requirements
Module: VX_cache_flush_ctrl

Interface
REQ-001 SHALL have parameter CACHE_SIZE, default 1024, cache size in bytes.
REQ-002 SHALL have parameter LINE_SIZE, default 16, line size in bytes.
REQ-003 SHALL have parameter NUM_BANKS, default 1, bank count.
REQ-004 SHALL have parameter NUM_WAYS, default 1, associativity.
REQ-005 SHALL have parameter WORD_SIZE, default 1, word size in bytes, used only for cache address macros.
REQ-006 SHALL have parameter MAX_PENDING, default 4, maximum outstanding dirty writebacks.
REQ-007 SHALL have port clk, input, 1, sole clock.
REQ-008 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-009 SHALL have port flush_req_valid, input, 1, core flush request.
REQ-010 SHALL have port flush_req_ready, output, 1, flush request accepted.
REQ-011 SHALL have port flush_rsp_valid, output, 1, flush complete.
REQ-012 SHALL have port flush_rsp_ready, input, 1, completion consumed.
REQ-013 SHALL have port flush_line, output, 1, per-line flush command to the tag/data pipeline.
REQ-014 SHALL have port flush_line_sel, output, `CS_LINE_SEL_BITS, line index being flushed.
REQ-015 SHALL have port flush_way_sel, output, NUM_WAYS, one-hot way being flushed.
REQ-016 SHALL have port flush_ready, input, 1, pipeline accepts flush command (not stalled).
REQ-017 SHALL have port wb_issue, input, 1, pipeline issued a dirty-line writeback to memory.
REQ-018 SHALL have port wb_done, input, 1, memory acknowledged one writeback.
REQ-019 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, WALK, DRAIN, DONE.
REQ-021 SHALL assert flush_req_ready only in IDLE; a handshake moves IDLE->WALK and clears line and way counters.
REQ-022 In WALK, SHALL assert flush_line when pending < MAX_PENDING; a command fires when flush_line && flush_ready.
REQ-023 SHALL order commands way-minor: line 0 way 0..NUM_WAYS-1, then line 1, up to line `CS_LINES_PER_BANK-1.
REQ-024 SHALL hold flush_line_sel and flush_way_sel stable while flush_line is high and flush_ready is low.
REQ-025 SHALL drive flush_way_sel as one-hot of the way counter; it SHALL be zero when flush_line is low.
REQ-026 On the fire of the last line/last way, SHALL move WALK->DRAIN.
REQ-027 SHALL keep a pending counter of width $clog2(MAX_PENDING+1): +1 on wb_issue, -1 on wb_done, unchanged on both.
REQ-028 SHALL flag wb_done at pending==0 without wb_issue, or wb_issue at pending==MAX_PENDING without wb_done, as an assertion error; the counter SHALL saturate.
REQ-029 SHALL move DRAIN->DONE when pending==0 and no wb_issue occurs in the same cycle.
REQ-030 In DONE, SHALL assert flush_rsp_valid and hold it until flush_rsp_ready, then move to IDLE.
REQ-031 SHALL count wb_issue/wb_done in every state, including IDLE.
REQ-032 With `CS_LINES_PER_BANK==1 and NUM_WAYS==1, SHALL issue exactly one command, then DRAIN.
REQ-033 flush_req_valid outside IDLE SHALL be ignored; no queueing.

Reset
REQ-034 On reset, SHALL enter IDLE and clear counters and pending.
REQ-035 During reset and the cycle after, outputs SHALL be: flush_req_ready=1 after reset, flush_rsp_valid=0, flush_line=0, flush_line_sel=0, flush_way_sel=0, busy=0.
REQ-036 Reset mid-walk or mid-drain SHALL abort with no flush_rsp_valid.

Structure
REQ-037 SHALL take line-count, select-width and address macros from VX_cache_define.vh; state encoding SHALL be a localparam enum local to the module.
REQ-038 SHALL be a single module; the one-hot way decode SHALL use the existing VX_decoder primitive if available, otherwise be inline.

Verification
REQ-039 CACHE_SIZE=1024, LINE_SIZE=16, NUM_WAYS=2, flush_ready=1, no writebacks -> 64 commands in 64 consecutive cycles (line 0/way 01 ... line 31/way 10), then flush_rsp_valid.
REQ-040 flush_ready toggled 0/1 every cycle -> 64 commands over 128 cycles; sel held stable on stall cycles.
REQ-041 MAX_PENDING=2, wb_issue on the first 3 fires, wb_done delayed 10 cycles -> flush_line low while pending==2; resumes after the first wb_done.
REQ-042 Walk finished with pending=1, wb_done 5 cycles later -> DRAIN 5 cycles, then DONE; flush_rsp_ready=0 for 3 cycles holds flush_rsp_valid.
REQ-043 Reset asserted at line 10 -> next cycle IDLE, pending=0, no response; a new request restarts at line 0 way 0.
REQ-044 flush_req_valid pulsed in WALK and DONE -> ignored; exactly one response per accepted request.

Source files
------------

// File: rtl/vx_cache_flush_ctrl_pkg.sv
// Cache geometry helpers shared by the flush controller: line count per bank
// and the select width needed to index those lines or ways.
package vx_cache_flush_ctrl_pkg;

  function automatic int lines_per_bank(input int cache_size, input int line_size,
                                        input int num_banks, input int num_ways);
    return cache_size / (line_size * num_banks * num_ways);
  endfunction

  // A select field is never narrower than one bit, even for a single entry.
  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_cache_flush_ctrl.sv
// Cache flush controller: walks every line/way of a bank issuing flush commands,
// throttles on outstanding dirty writebacks, then drains them before responding.
module vx_cache_flush_ctrl
  import vx_cache_flush_ctrl_pkg::*;
#(
  parameter int CACHE_SIZE  = 1024,
  parameter int LINE_SIZE   = 16,
  parameter int NUM_BANKS   = 1,
  parameter int NUM_WAYS    = 1,
  parameter int WORD_SIZE   = 1,
  parameter int MAX_PENDING = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic flush_req_valid,
  output logic flush_req_ready,
  output logic flush_rsp_valid,
  input  logic flush_rsp_ready,
  output logic flush_line,
  output logic [sel_bits(lines_per_bank(CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS))-1:0] flush_line_sel,
  output logic [NUM_WAYS-1:0] flush_way_sel,
  input  logic flush_ready,
  input  logic wb_issue,
  input  logic wb_done,
  output logic busy
);

  localparam int LINES = lines_per_bank(CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS);
  localparam int LSB   = sel_bits(LINES);
  localparam int WB    = sel_bits(NUM_WAYS);
  localparam int PW    = $clog2(MAX_PENDING + 1);

  localparam logic [LSB-1:0] LINE_LAST = LSB'(LINES - 1);
  localparam logic [WB-1:0]  WAY_LAST  = WB'(NUM_WAYS - 1);
  localparam logic [PW-1:0]  PEND_MAX  = PW'(MAX_PENDING);

  if (LINE_SIZE % WORD_SIZE != 0) begin : g_bad_word_size
    $error("LINE_SIZE must be a multiple of WORD_SIZE");
  end

  typedef enum logic [1:0] {IDLE, WALK, DRAIN, DONE} state_e;

  state_e           r_state;
  state_e           w_next;
  logic [LSB-1:0]   r_line;
  logic [WB-1:0]    r_way;
  logic [PW-1:0]    r_pending;
  logic             w_can_issue;
  logic             w_fire;
  logic             w_last;
  logic             w_accept;
  logic             w_inc;
  logic             w_dec;

  assign w_can_issue = (r_state == WALK) && (r_pending < PEND_MAX);
  assign w_fire      = w_can_issue && flush_ready;
  assign w_last      = (r_line == LINE_LAST) && (r_way == WAY_LAST);
  assign w_accept    = flush_req_valid && (r_state == IDLE);
  assign w_inc       = wb_issue && !wb_done;
  assign w_dec       = wb_done && !wb_issue;

  assign flush_line     = w_can_issue;
  assign flush_line_sel = r_line;
  assign busy           = (r_state != IDLE);

  always_comb begin
    flush_way_sel = '0;
    if (w_can_issue) begin
      flush_way_sel[r_way] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    flush_req_ready = 1'b0;
    flush_rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        flush_req_ready = 1'b1;
        if (flush_req_valid) w_next = WALK;
      end
      WALK: begin
        if (w_fire && w_last) w_next = DRAIN;
      end
      // A writeback issued this cycle means the drain is not finished yet.
      DRAIN: begin
        if ((r_pending == '0) && !wb_issue) w_next = DONE;
      end
      DONE: begin
        flush_rsp_valid = 1'b1;
        if (flush_rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Way-minor walk: the way counter wraps into the line counter.
  always_ff @(posedge clk) begin
    if (reset || w_accept) begin
      r_line <= '0;
      r_way  <= '0;
    end else if (w_fire) begin
      if (r_way == WAY_LAST) begin
        r_way  <= '0;
        r_line <= r_line + LSB'(1);
      end else begin
        r_way <= r_way + WB'(1);
      end
    end
  end

  // Tracked in every state so writebacks straddling a request stay accounted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
    end else if (w_inc && (r_pending != PEND_MAX)) begin
      r_pending <= r_pending + PW'(1);
    end else if (w_dec && (r_pending != '0)) begin
      r_pending <= r_pending - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(w_dec && (r_pending == '0)))
        else $error("wb_done with no writeback pending");
      assert (!(w_inc && (r_pending == PEND_MAX)))
        else $error("wb_issue beyond MAX_PENDING outstanding writebacks");
    end
  end

endmodule
